fir_mdc_tcdm_arbiter: RTL and testbench



---
 rtl/fir_mdc_package.sv | 20 ++
 rtl/fir_mdc_arb_id_fifo.sv | 62 ++++++
 rtl/fir_mdc_tcdm_arbiter.sv | 105 ++++++++++
 tb/tb_fir_mdc_tcdm_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_mdc_package.sv
// fir_mdc_package: shared parameters and types for the fir_mdc TCDM arbiter.
`default_nettype none

package fir_mdc_package;

   localparam int FIR_MDC_ARB_N_REQ   = 3;
   localparam int FIR_MDC_ARB_MAX_OUT = 4;

   // A single requester still needs a 1-bit ID field to keep widths legal
   function automatic int fir_mdc_arb_id_width(input int n_req);
      return (n_req > 1) ? $clog2(n_req) : 1;
   endfunction

   localparam int FIR_MDC_ARB_ID_W = fir_mdc_arb_id_width(FIR_MDC_ARB_N_REQ);

   typedef logic [FIR_MDC_ARB_ID_W-1:0] fir_mdc_arb_id_t;

endpackage

`default_nettype wire

// File: rtl/fir_mdc_arb_id_fifo.sv
// fir_mdc_arb_id_fifo: in-order requester-ID FIFO, registered outputs, no fall-through.
`default_nettype none

module fir_mdc_arb_id_fifo #(
   parameter  int DEPTH = 4,
   parameter  int W     = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     data_i,
   output logic [W-1:0]     data_o,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             w_push, w_pop;

   assign full   = (count_q == CNT_W'(DEPTH));
   assign empty  = (count_q == '0);
   assign count  = count_q;
   assign data_o = mem_q[rd_ptr_q];

   // Guard against overflow/underflow even if the caller misbehaves
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;

   always_comb begin
      count_d = count_q;
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

`default_nettype wire

// File: rtl/fir_mdc_tcdm_arbiter.sv
// fir_mdc_tcdm_arbiter: round-robin share of one TCDM master port among N_REQ
// streamers, with in-order response steering through an ID FIFO.
`default_nettype none

module fir_mdc_tcdm_arbiter
   import fir_mdc_package::*;
#(
   parameter int N_REQ   = FIR_MDC_ARB_N_REQ,
   parameter int MAX_OUT = FIR_MDC_ARB_MAX_OUT
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [N_REQ-1:0]       in_req,
   output logic [N_REQ-1:0]       in_gnt,
   input  logic [N_REQ-1:0][31:0] in_add,
   input  logic [N_REQ-1:0]       in_wen,
   input  logic [N_REQ-1:0][3:0]  in_be,
   input  logic [N_REQ-1:0][31:0] in_data,
   output logic [N_REQ-1:0][31:0] in_r_data,
   output logic [N_REQ-1:0]       in_r_valid,
   output logic                   out_req,
   input  logic                   out_gnt,
   output logic [31:0]            out_add,
   output logic                   out_wen,
   output logic [3:0]             out_be,
   output logic [31:0]            out_data,
   input  logic [31:0]            out_r_data,
   input  logic                   out_r_valid,
   output logic                   busy_o,
   output logic                   err_o
);

   localparam int ID_W  = fir_mdc_arb_id_width(N_REQ);
   localparam int CNT_W = $clog2(MAX_OUT + 1);

   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  w_sel, w_head_id;
   logic             w_any, w_full, w_empty, w_hs, w_pop;
   logic [CNT_W-1:0] w_count;
   logic             err_q;

   // Rotating priority scan starting at rr_ptr, wrapping at N_REQ-1
   always_comb begin : p_arb
      int idx;
      idx   = 0;
      w_any = 1'b0;
      w_sel = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!w_any && in_req[idx]) begin
            w_any = 1'b1;
            w_sel = ID_W'(idx);
         end
      end
   end

   assign out_req  = w_any & ~w_full;
   assign w_hs     = out_req & out_gnt;
   assign out_add  = out_req ? in_add[w_sel]  : '0;
   assign out_wen  = out_req ? in_wen[w_sel]  : 1'b0;
   assign out_be   = out_req ? in_be[w_sel]   : '0;
   assign out_data = out_req ? in_data[w_sel] : '0;

   assign w_pop  = out_r_valid & ~w_empty;
   assign busy_o = (w_count != '0);
   assign err_o  = err_q;

   for (genvar i = 0; i < N_REQ; i++) begin : g_port
      assign in_gnt[i]     = w_hs & (w_sel == ID_W'(i));
      assign in_r_valid[i] = w_pop & (w_head_id == ID_W'(i));
      assign in_r_data[i]  = out_r_data;
   end

   assign rr_ptr_d = !w_hs ? rr_ptr_q :
                     (w_sel == ID_W'(N_REQ - 1)) ? '0 : w_sel + 1'b1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         if (out_r_valid && w_empty) err_q <= 1'b1;
      end
   end

   fir_mdc_arb_id_fifo #(
      .DEPTH (MAX_OUT),
      .W     (ID_W)
   ) u_id_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push   (w_hs),
      .pop    (w_pop),
      .data_i (w_sel),
      .data_o (w_head_id),
      .full   (w_full),
      .empty  (w_empty),
      .count  (w_count)
   );

endmodule

`default_nettype wire

// File: tb/tb_fir_mdc_tcdm_arbiter.sv
// tb_fir_mdc_tcdm_arbiter: directed self-checking bench for fir_mdc_tcdm_arbiter.
`default_nettype none

module tb_fir_mdc_tcdm_arbiter;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b0;
   logic [2:0]       in_req;
   logic [2:0]       in_gnt;
   logic [2:0][31:0] in_add;
   logic [2:0]       in_wen;
   logic [2:0][3:0]  in_be;
   logic [2:0][31:0] in_data;
   logic [2:0][31:0] in_r_data;
   logic [2:0]       in_r_valid;
   logic             out_req;
   logic             out_gnt;
   logic [31:0]      out_add;
   logic             out_wen;
   logic [3:0]       out_be;
   logic [31:0]      out_data;
   logic [31:0]      out_r_data;
   logic             out_r_valid;
   logic             busy_o;
   logic             err_o;

   int n_vec = 0;
   int n_err = 0;

   fir_mdc_tcdm_arbiter dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_req      (in_req),
      .in_gnt      (in_gnt),
      .in_add      (in_add),
      .in_wen      (in_wen),
      .in_be       (in_be),
      .in_data     (in_data),
      .in_r_data   (in_r_data),
      .in_r_valid  (in_r_valid),
      .out_req     (out_req),
      .out_gnt     (out_gnt),
      .out_add     (out_add),
      .out_wen     (out_wen),
      .out_be      (out_be),
      .out_data    (out_data),
      .out_r_data  (out_r_data),
      .out_r_valid (out_r_valid),
      .busy_o      (busy_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      in_req      = '0;
      out_gnt     = 1'b0;
      out_r_valid = 1'b0;
      out_r_data  = '0;
      in_add      = {32'h3000, 32'h2000, 32'h1000};
      in_wen      = 3'b111;
      in_be       = {4'hC, 4'h3, 4'hF};
      in_data     = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      rst_i = 1'b1;
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      in_req = '0; out_gnt = 1'b0; out_r_valid = 1'b0;
      rst_i = 1'b1;
      #3;
      n_vec++; if (in_gnt !== 3'b000) begin n_err++; $display("FAIL rst_gnt: got %b expected 000", in_gnt); end
      n_vec++; if (in_r_valid !== 3'b000) begin n_err++; $display("FAIL rst_rvalid: got %b expected 000", in_r_valid); end
      n_vec++; if (out_req !== 1'b0) begin n_err++; $display("FAIL rst_out_req: got %b expected 0", out_req); end
      n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
      n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b expected 0", err_o); end
      do_reset();
   endtask

   task automatic test_single();
      logic [31:0] addrs [3] = '{32'h100, 32'h104, 32'h108};
      logic [31:0] rdat  [3] = '{32'hA, 32'hB, 32'hC};
      do_reset();
      for (int c = 0; c < 5; c++) begin
         tick();
         in_req      = (c < 3) ? 3'b010 : 3'b000;
         out_gnt     = 1'b1;
         in_add[1]   = (c < 3) ? addrs[c] : 32'h0;
         out_r_valid = (c >= 1 && c <= 3);
         out_r_data  = (c >= 1 && c <= 3) ? rdat[c-1] : 32'h0;
         #3;
         n_vec++; if (in_gnt !== ((c < 3) ? 3'b010 : 3'b000)) begin n_err++; $display("FAIL single_gnt c=%0d: got %b", c, in_gnt); end
         if (c < 3) begin
            n_vec++; if (out_add !== addrs[c] || out_wen !== 1'b1 || out_be !== 4'h3) begin n_err++; $display("FAIL single_fields c=%0d: got add %h wen %b be %h expected %h 1 3", c, out_add, out_wen, out_be, addrs[c]); end
         end
         if (c >= 1 && c <= 3) begin
            n_vec++; if (in_r_valid !== 3'b010) begin n_err++; $display("FAIL single_rvalid c=%0d: got %b expected 010", c, in_r_valid); end
            n_vec++; if (in_r_data[1] !== rdat[c-1] || in_r_data[0] !== rdat[c-1]) begin n_err++; $display("FAIL single_rdata c=%0d: got %h expected %h", c, in_r_data[1], rdat[c-1]); end
            n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL single_busy c=%0d: got %b expected 1", c, busy_o); end
         end
      end
      n_vec++; if (busy_o !== 1'b0 || in_r_valid !== 3'b000) begin n_err++; $display("FAIL single_idle: busy %b rvalid %b expected 0 000", busy_o, in_r_valid); end
   endtask

   task automatic test_fairness();
      logic [2:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      do_reset();
      for (int c = 0; c < 7; c++) begin
         tick();
         in_req      = (c < 6) ? 3'b111 : 3'b000;
         out_gnt     = 1'b1;
         out_r_valid = (c >= 1);
         out_r_data  = 32'h100 + c;
         #3;
         if (c < 6) begin
            n_vec++; if (in_gnt !== exp_g[c]) begin n_err++; $display("FAIL fair_gnt c=%0d: got %b expected %b", c, in_gnt, exp_g[c]); end
         end
         if (c >= 1) begin
            n_vec++; if (in_r_valid !== exp_g[c-1]) begin n_err++; $display("FAIL fair_rvalid c=%0d: got %b expected %b", c, in_r_valid, exp_g[c-1]); end
         end
      end
      tick();
      out_r_valid = 1'b0;
      #3;
      n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL fair_drain: busy got %b expected 0", busy_o); end
   endtask

   task automatic test_backpressure();
      do_reset();
      in_wen[2]  = 1'b0;
      in_data[2] = 32'hDEAD_BEEF;
      for (int c = 0; c < 5; c++) begin
         tick();
         in_req  = 3'b101;
         out_gnt = 1'b0;
         #3;
         n_vec++; if (out_req !== 1'b1 || out_add !== 32'h1000 || in_gnt !== 3'b000) begin n_err++; $display("FAIL bp_hold c=%0d: req %b add %h gnt %b expected 1 00001000 000", c, out_req, out_add, in_gnt); end
      end
      tick();
      out_gnt = 1'b1;
      #3;
      n_vec++; if (in_gnt !== 3'b001 || out_add !== 32'h1000) begin n_err++; $display("FAIL bp_first: gnt %b add %h expected 001 00001000", in_gnt, out_add); end
      tick();
      #3;
      n_vec++; if (in_gnt !== 3'b100 || out_add !== 32'h3000) begin n_err++; $display("FAIL bp_second: gnt %b add %h expected 100 00003000", in_gnt, out_add); end
      n_vec++; if (out_wen !== 1'b0 || out_data !== 32'hDEAD_BEEF || out_be !== 4'hC) begin n_err++; $display("FAIL bp_write: wen %b data %h be %h expected 0 deadbeef c", out_wen, out_data, out_be); end
      tick();
      in_req = 3'b000; out_gnt = 1'b0;
   endtask

   task automatic test_full();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         tick();
         in_req = 3'b001; out_gnt = 1'b1; out_r_valid = 1'b0;
         #3;
         n_vec++; if (in_gnt !== 3'b001) begin n_err++; $display("FAIL full_fill c=%0d: gnt %b expected 001", c, in_gnt); end
      end
      tick();
      out_r_valid = 1'b1; out_r_data = 32'h55;
      #3;
      n_vec++; if (out_req !== 1'b0 || in_gnt !== 3'b000) begin n_err++; $display("FAIL full_block: req %b gnt %b expected 0 000", out_req, in_gnt); end
      n_vec++; if (in_r_valid !== 3'b001 || in_r_data[0] !== 32'h55) begin n_err++; $display("FAIL full_pop: rvalid %b data %h expected 001 55", in_r_valid, in_r_data[0]); end
      tick();
      out_r_valid = 1'b0;
      #3;
      n_vec++; if (out_req !== 1'b1 || in_gnt !== 3'b001) begin n_err++; $display("FAIL full_reopen: req %b gnt %b expected 1 001", out_req, in_gnt); end
      tick();
      in_req = 3'b000; out_gnt = 1'b0;
   endtask

   task automatic test_stray();
      do_reset();
      tick();
      out_r_valid = 1'b1; out_r_data = 32'h77;
      #3;
      n_vec++; if (in_r_valid !== 3'b000 || err_o !== 1'b0) begin n_err++; $display("FAIL stray_now: rvalid %b err %b expected 000 0", in_r_valid, err_o); end
      for (int c = 0; c < 3; c++) begin
         tick();
         out_r_valid = 1'b0;
         #3;
         n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL stray_sticky c=%0d: err %b expected 1", c, err_o); end
      end
      do_reset();
      #3;
      n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL stray_clear: err %b expected 0", err_o); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      tick();
      in_req = 3'b011; out_gnt = 1'b1;
      #3;
      n_vec++; if (in_gnt !== 3'b001) begin n_err++; $display("FAIL mid_g0: gnt %b expected 001", in_gnt); end
      tick();
      #3;
      n_vec++; if (in_gnt !== 3'b010) begin n_err++; $display("FAIL mid_g1: gnt %b expected 010", in_gnt); end
      tick();
      in_req = 3'b000; out_gnt = 1'b0;
      #1;
      n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b expected 1", busy_o); end
      #1;
      rst_i = 1'b1;
      #1;
      n_vec++; if (busy_o !== 1'b0 || in_gnt !== 3'b000 || err_o !== 1'b0) begin n_err++; $display("FAIL mid_async: busy %b gnt %b err %b expected 0 000 0", busy_o, in_gnt, err_o); end
      tick();
      rst_i = 1'b0;
      tick();
      in_req = 3'b111; out_gnt = 1'b1;
      #3;
      n_vec++; if (in_gnt !== 3'b001) begin n_err++; $display("FAIL mid_regrant: gnt %b expected 001", in_gnt); end
      tick();
      in_req = 3'b000; out_gnt = 1'b0; out_r_valid = 1'b1;
      #3;
      n_vec++; if (in_r_valid !== 3'b001) begin n_err++; $display("FAIL mid_resp: rvalid %b expected 001", in_r_valid); end
      tick();
      out_r_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_full();
      test_stray();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
